// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch core: FSM encodings, BCD digit limits
// and the packed mm:ss time word.
package stopwatch_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;

  localparam logic [3:0] SEC_ONES_MAX = 4'd9;
  localparam logic [3:0] SEC_TENS_MAX = 4'd5;
  localparam logic [3:0] MIN_ONES_MAX = 4'd9;

  typedef struct packed {
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
  } bcd_time_t;

  // Next value of one BCD digit; wraps to zero at its maximum.
  function automatic logic [3:0] bcd_next(input logic [3:0] digit, input logic [3:0] max_val);
    return (digit == max_val) ? 4'd0 : digit + 4'd1;
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Button synchroniser plus rising-edge detector; emits one registered
// single-cycle pulse per press regardless of how long the button is held.
module btn_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic Clk_100mhz,
  input  logic Rst_n,
  input  logic btn_i,
  output logic pulse_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   pulse_q;

  always_ff @(posedge Clk_100mhz or negedge Rst_n) begin
    if (!Rst_n) begin
      sync_q  <= '0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], btn_i};
      prev_q  <= sync_q[SYNC_STAGES-1];
      pulse_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch time-keeping core: start/stop/clear/lap control and a BCD mm:ss
// counter advanced by the 1 Hz tick, with a registered (optionally frozen) display.
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int MIN_TENS_MAX = 5
) (
  input  logic       Clk_100mhz,
  input  logic       Rst_n,
  input  logic       Tick_1hz,
  input  logic       Btn_start_stop,
  input  logic       Btn_clear,
  input  logic       Btn_lap,
  output logic [3:0] Sec_ones,
  output logic [3:0] Sec_tens,
  output logic [3:0] Min_ones,
  output logic [3:0] Min_tens,
  output logic       Running,
  output logic       Lap_hold,
  output logic       Overflow
);

  localparam logic [3:0] MIN_TENS_LIM = 4'(MIN_TENS_MAX);

  logic ss_p, clr_p, lap_p;

  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ss (
    .Clk_100mhz(Clk_100mhz), .Rst_n(Rst_n), .btn_i(Btn_start_stop), .pulse_o(ss_p));
  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clr (
    .Clk_100mhz(Clk_100mhz), .Rst_n(Rst_n), .btn_i(Btn_clear), .pulse_o(clr_p));
  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_lap (
    .Clk_100mhz(Clk_100mhz), .Rst_n(Rst_n), .btn_i(Btn_lap), .pulse_o(lap_p));

  logic [1:0] state_q, state_d;
  bcd_time_t  cnt_q, cnt_d;
  bcd_time_t  disp_q, disp_d;
  logic       hold_q, hold_d;
  logic       running_q, running_d;
  logic       ovf_q, ovf_d;

  logic adv, so_wrap, st_wrap, mo_wrap, mt_wrap;

  always_comb begin
    adv     = Tick_1hz && (state_q == ST_RUN);
    so_wrap = (cnt_q.sec_ones == SEC_ONES_MAX);
    st_wrap = (cnt_q.sec_tens == SEC_TENS_MAX);
    mo_wrap = (cnt_q.min_ones == MIN_ONES_MAX);
    mt_wrap = (cnt_q.min_tens == MIN_TENS_LIM);

    cnt_d     = cnt_q;
    ovf_d     = 1'b0;
    state_d   = state_q;
    hold_d    = hold_q;
    disp_d    = hold_q ? disp_q : cnt_q;

    // Clear overrides tick, start/stop and lap arriving in the same cycle.
    if (clr_p) begin
      cnt_d   = '0;
      state_d = ST_IDLE;
      hold_d  = 1'b0;
    end else begin
      if (adv) begin
        cnt_d.sec_ones = bcd_next(cnt_q.sec_ones, SEC_ONES_MAX);
        if (so_wrap) begin
          cnt_d.sec_tens = bcd_next(cnt_q.sec_tens, SEC_TENS_MAX);
          if (st_wrap) begin
            cnt_d.min_ones = bcd_next(cnt_q.min_ones, MIN_ONES_MAX);
            if (mo_wrap) begin
              cnt_d.min_tens = bcd_next(cnt_q.min_tens, MIN_TENS_LIM);
              ovf_d          = mt_wrap;
            end
          end
        end
      end

      if (ss_p) begin
        case (state_q)
          ST_IDLE:  state_d = ST_RUN;
          ST_RUN:   state_d = ST_PAUSE;
          ST_PAUSE: state_d = ST_RUN;
          default:  state_d = ST_IDLE;
        endcase
      end

      if (lap_p && (state_q == ST_RUN)) begin
        hold_d = ~hold_q;
      end
    end

    running_d = (state_d == ST_RUN);
  end

  always_ff @(posedge Clk_100mhz or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      disp_q    <= '0;
      hold_q    <= 1'b0;
      running_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      disp_q    <= disp_d;
      hold_q    <= hold_d;
      running_q <= running_d;
      ovf_q     <= ovf_d;
    end
  end

  assign Sec_ones = disp_q.sec_ones;
  assign Sec_tens = disp_q.sec_tens;
  assign Min_ones = disp_q.min_ones;
  assign Min_tens = disp_q.min_tens;
  assign Running  = running_q;
  assign Lap_hold = hold_q;
  assign Overflow = ovf_q;

endmodule
